// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-count tracker.
package gray_pkg;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Cycles spent in SEED before the first sample is trusted (synchronizer depth).
  localparam int unsigned SEED_FILL = 2;

  // Widest code the helpers handle. Narrower codes are zero-extended, which
  // leaves the conversion of the low bits unchanged.
  localparam int unsigned MAX_W = 32;

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] i_g);
    logic [MAX_W-1:0] v_b;
    v_b[MAX_W-1] = i_g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      v_b[i] = v_b[i+1] ^ i_g[i];
    end
    return v_b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] i_b);
    return i_b ^ (i_b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus; the only sampling point of the
// asynchronous source.
module gray_sync_2ff #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/gray_count_tracker.sv
// Tracks a synchronized Gray count: decodes it, classifies each change as
// +1 / -1 / illegal, keeps a signed position and a saturating error count.
//
// state | meaning
// ------+-------------------------------------------------------------
// SEED  | after reset; wait for synchronizer fill, then seed prev
// TRACK | locked; each new sample must be 0 or +/-1 away from prev
// FAULT | illegal jump seen; wait for a stable input, then re-seed
module gray_count_tracker
  import gray_pkg::*;
#(
  parameter int unsigned W          = 3,
  parameter int unsigned POS_W      = 16,
  parameter int unsigned ERRC_W     = 8,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [W-1:0]      i_gray_in,
  input  logic              i_clr,
  output logic [W-1:0]      o_bin_out,
  output logic              o_step_up,
  output logic              o_step_down,
  output logic              o_err,
  output logic              o_locked,
  output logic [POS_W-1:0]  o_position,
  output logic [ERRC_W-1:0] o_err_count
);

  localparam logic [1:0]       C_SEED_LAST = 2'(SEED_FILL);
  localparam logic [7:0]       C_STABLE    = 8'(STABLE_CYC);
  localparam logic [W-1:0]     C_DELTA_UP  = W'(1);
  localparam logic [POS_W-1:0] C_POS_ONE   = POS_W'(1);
  localparam logic [ERRC_W-1:0] C_ERR_ONE  = ERRC_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W-1:0]        w_s2;
  logic [W-1:0]        w_b;
  logic [W-1:0]        w_delta;
  logic [W-1:0]        r_prev;
  logic [W-1:0]        r_s2_d;
  logic [1:0]          r_seed_cnt;
  logic [7:0]          r_stab;
  logic [7:0]          w_stab_inc;
  logic                w_seed_done;
  logic                w_relock;
  logic                w_is_up;
  logic                w_is_dn;
  logic                w_is_err;
  logic                r_step_up;
  logic                r_step_down;
  logic                r_err;
  logic                r_locked;
  logic [POS_W-1:0]    r_position;
  logic [ERRC_W-1:0]   r_err_count;

  gray_sync_2ff #(.W(W)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_gray_in),
    .o_q   (w_s2)
  );

  assign w_b     = W'(gray2bin(MAX_W'(w_s2)));
  assign w_delta = w_b - r_prev;

  // Classify the current sample and decide the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_seed_done = 1'b0;
    w_relock    = 1'b0;
    w_is_up     = 1'b0;
    w_is_dn     = 1'b0;
    w_is_err    = 1'b0;
    w_stab_inc  = (w_s2 == r_s2_d) ? (r_stab + 8'd1) : 8'd0;
    case (r_state)
      SEED: begin
        if (r_seed_cnt == C_SEED_LAST) begin
          w_seed_done = 1'b1;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        // A zero delta must win over the all-ones check.
        if (w_delta == '0) begin
          w_is_up = 1'b0;
        end else if (w_delta == C_DELTA_UP) begin
          w_is_up = 1'b1;
        end else if (w_delta == '1) begin
          w_is_dn = 1'b1;
        end else begin
          w_is_err    = 1'b1;
          w_state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (w_stab_inc == C_STABLE) begin
          w_relock    = 1'b1;
          w_state_nxt = TRACK;
        end
      end
      default: w_state_nxt = SEED;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SEED;
    else       r_state <= w_state_nxt;
  end

  // Synchronizer-fill counter used only while seeding.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                  r_seed_cnt <= '0;
    else if (r_state == SEED && !w_seed_done)   r_seed_cnt <= r_seed_cnt + 2'd1;
  end

  // Stability counter: cleared on fault entry, counts unchanged samples in FAULT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stab <= '0;
      r_s2_d <= '0;
    end else begin
      r_s2_d <= w_s2;
      if (w_is_err)                r_stab <= '0;
      else if (r_state == FAULT)   r_stab <= w_stab_inc;
    end
  end

  // Last accepted binary value, which is also the visible bin_out.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= '0;
    else if (w_seed_done || w_relock || w_is_up || w_is_dn) r_prev <= w_b;
  end

  // Registered one-cycle pulses and lock flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_up   <= 1'b0;
      r_step_down <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_step_up   <= w_is_up;
      r_step_down <= w_is_dn;
      r_err       <= w_is_err;
      r_locked    <= (w_state_nxt == TRACK);
    end
  end

  // Position accumulator; clear overrides a same-cycle step, wraps freely.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_position <= '0;
    else if (i_clr)   r_position <= '0;
    else if (w_is_up) r_position <= r_position + C_POS_ONE;
    else if (w_is_dn) r_position <= r_position - C_POS_ONE;
  end

  // Saturating error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst)                              r_err_count <= '0;
    else if (i_clr)                         r_err_count <= '0;
    else if (w_is_err && r_err_count != '1) r_err_count <= r_err_count + C_ERR_ONE;
  end

  assign o_bin_out   = r_prev;
  assign o_step_up   = r_step_up;
  assign o_step_down = r_step_down;
  assign o_err       = r_err;
  assign o_locked    = r_locked;
  assign o_position  = r_position;
  assign o_err_count = r_err_count;

endmodule

// File: doc/gray_count_tracker.md
# gray_count_tracker

Receive-side companion to the gray-code counter. Samples a W-bit reflected-Gray count driven from elsewhere, possibly asynchronous to `clk`, through a two-flop synchronizer and decodes it to binary. Classifies each change as a single step up, a single step down or an illegal jump, and accumulates a signed position. Sits between any Gray-coded counter source and the logic that needs binary position, direction and integrity status.

## Interface
- `W`, 3: Gray/binary width.
- `POS_W`, 16: width of accumulated position (two's complement).
- `ERRC_W`, 8: width of saturating error counter.
- `STABLE_CYC`, 4: consecutive unchanged synced samples required to re-lock after a fault (1..255).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `gray_in`  in  W  Gray count from source; may change at any time.
- `clr`  in  1  synchronous clear of `position` and `err_count`.
- `bin_out`  out  W  decoded binary of last accepted sample.
- `step_up`  out  1  one-cycle pulse: accepted +1 step (mod 2^W).
- `step_down`  out  1  one-cycle pulse: accepted −1 step (mod 2^W).
- `err`  out  1  one-cycle pulse: illegal jump detected.
- `locked`  out  1  high while in TRACK.
- `position`  out  POS_W  signed running sum of steps.
- `err_count`  out  ERRC_W  number of `err` pulses, saturating.

## Operation
- Synchronizer: `s1 <= gray_in; s2 <= s1`; both reset to 0. Decode: `b[W-1]=s2[W-1]`, `b[i]=b[i+1]^s2[i]`.
- `prev` register holds last accepted binary value. Define `delta = b − prev` mod 2^W.
- States:
  - SEED: entered on reset. Waits 2 cycles for synchronizer fill. On the 3rd edge after `rst` falls, `prev <= b`, `bin_out <= b`, no pulse, go to TRACK.
  - TRACK:
    - delta 0: nothing.
    - delta 1: `step_up`, `position+1`.
    - delta 2^W−1: `step_down`, `position−1`.
    - Otherwise: `err` pulse, `err_count+1` (saturate at all-ones), position unchanged, `bin_out`/`prev` unchanged, go to FAULT.
    - Delta 0 must be checked before delta 2^W−1.
  - FAULT:
    - Stability counter increments on each cycle where `s2` equals its previous value, and resets to 0 on any change.
    - When the counter reaches `STABLE_CYC`: `prev <= b`, `bin_out <= b`, no step pulse, go to TRACK.
    - Counter is cleared on entry to FAULT.
- `position` wraps modulo 2^POS_W. No saturation.
- `clr` has priority over a same-cycle step. `position <= 0` and `err_count <= 0`, and the step/err pulse still fires. `clr` does not change state, `prev` or `bin_out`.
- `rst` mid-operation (any state): next edge all registers take reset values and the state returns to SEED.
- Reset values: `bin_out=0`, `step_up=0`, `step_down=0`, `err=0`, `locked=0`, `position=0`, `err_count=0`, state SEED.

## Timing
- All outputs are registered.
- A `gray_in` value stable before rising edge n is captured in `s1` at n and `s2` at n+1. The resulting `bin_out`/pulse is visible after edge n+2, i.e. 3-cycle latency.
- Pulses are exactly one cycle wide. At most one of `step_up`/`step_down`/`err` is high per cycle.
- Source must hold each code ≥2 `clk` cycles. Faster changes may be reported as `err`; this is required behaviour, not a bug.
- `locked` rises in the same cycle `bin_out` is seeded and falls in the same cycle `err` pulses.

## Structure
- Package `gray_pkg`:
  - state enum {SEED, TRACK, FAULT};
  - `gray2bin` and `bin2gray` functions, parameterized by width (`bin2gray` is for the bench);
  - constants for SEED fill length (2).
- Sub-module `gray_sync_2ff`: W-bit two-flop synchronizer with synchronous reset. It is the only place `gray_in` is sampled.
- Top holds the FSM, `prev`, delta compare, position and error counters.

## Test plan
- Reset, hold `gray_in=000`: `locked=1` and `bin_out=0` after the 3rd edge post-reset. No pulses, `position=0`.
- Drive 000,001,011,010,110,111,101,100,000, 3 cycles each: 8 `step_up` pulses, `bin_out` 0..7 then 0, `position=8`.
- From locked at 000, drive 100: one `step_down`, `bin_out=7`, `position=0xFFFF`.
- From 000, jump to 011:
  - expected: `err` pulse, `err_count=1`, `locked=0`, `bin_out=0`;
  - hold 011 ≥ `STABLE_CYC`+2 cycles, then expect `locked=1`, `bin_out=2`, no step;
  - then drive 010: `step_up`, `bin_out=3`, position +1.
- Assert `clr` in the cycle a `step_up` fires, with `position=5` and `err_count=3`: `step_up=1`, `position=0`, `err_count=0`. Also force 300 faults with `ERRC_W=8`: `err_count=255`.
- Assert `rst` for 1 cycle while in FAULT: all outputs at reset values next edge, then SEED again, re-locking on current `gray_in`.
